// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage req/ack data-memory controller with pipeline stall and MEM/WB bubble insertion
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_mem_memread,
    input  logic          ex_mem_memwrite,
    input  logic          ex_mem_regwrite,
    input  logic          ex_mem_memtoreg,
    input  logic [AW-1:0] ex_mem_alu_result,
    input  logic [DW-1:0] ex_mem_wdata,
    input  logic [4:0]    ex_mem_rd,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          stall,
    output logic          mem_wb_regwrite,
    output logic          mem_wb_memtoreg,
    output logic [DW-1:0] mem_wb_rdata,
    output logic [AW-1:0] mem_wb_alu_result,
    output logic [4:0]    mem_wb_rd,
    output logic          mem_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic          memop;
    logic          stall_c;
    logic          timeout_hit;
    logic          aborted;

    logic          dmem_req_q, dmem_req_d;
    logic          dmem_we_q, dmem_we_d;
    logic [AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [DW-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          wb_regwrite_q, wb_regwrite_d;
    logic          wb_memtoreg_q, wb_memtoreg_d;
    logic [DW-1:0] wb_rdata_q, wb_rdata_d;
    logic [AW-1:0] wb_alu_q, wb_alu_d;
    logic [4:0]    wb_rd_q, wb_rd_d;

    assign memop = ex_mem_memread | ex_mem_memwrite;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       abort_q, abort_d;
    logic       mem_err_q, mem_err_d;

    // A same-cycle ack takes priority over the timeout.
    assign timeout_hit = (state_q == ACCESS) && !dmem_ack && (cnt_q == 4'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && memop) begin
            cnt_d = 4'd0;
        end else if (state_q == ACCESS && !dmem_ack) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        abort_d = abort_q;
        if (timeout_hit) begin
            abort_d = 1'b1;
        end else if (state_q == DONE) begin
            abort_d = 1'b0;
        end
    end

    assign mem_err_d = timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 4'd0;
            abort_q   <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign aborted = abort_q;
    assign mem_err = mem_err_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign aborted        = 1'b0;
    assign mem_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (memop) state_d = ACCESS;
            ACCESS:  if (dmem_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_c       = 1'b0;
        dmem_req_d    = dmem_req_q;
        dmem_we_d     = dmem_we_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_wdata_d  = dmem_wdata_q;
        hold_d        = hold_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_memtoreg_d = wb_memtoreg_q;
        wb_rdata_d    = wb_rdata_q;
        wb_alu_d      = wb_alu_q;
        wb_rd_d       = wb_rd_q;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    stall_c       = 1'b1;
                    dmem_req_d    = 1'b1;
                    dmem_we_d     = ex_mem_memwrite;
                    dmem_addr_d   = ex_mem_alu_result;
                    dmem_wdata_d  = ex_mem_wdata;
                    wb_regwrite_d = 1'b0;
                end else begin
                    wb_regwrite_d = ex_mem_regwrite;
                    wb_memtoreg_d = ex_mem_memtoreg;
                    wb_rdata_d    = '0;
                    wb_alu_d      = ex_mem_alu_result;
                    wb_rd_d       = ex_mem_rd;
                end
            end
            ACCESS: begin
                stall_c       = 1'b1;
                wb_regwrite_d = 1'b0;
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    hold_d     = dmem_we_q ? '0 : dmem_rdata;
                end else if (timeout_hit) begin
                    dmem_req_d = 1'b0;
                    hold_d     = '0;
                end
            end
            DONE: begin
                // EX/MEM still holds the completed instruction because upstream was stalled.
                wb_regwrite_d = ex_mem_regwrite & ~aborted;
                wb_memtoreg_d = ex_mem_memtoreg;
                wb_rdata_d    = aborted ? '0 : hold_q;
                wb_alu_d      = ex_mem_alu_result;
                wb_rd_d       = ex_mem_rd;
            end
            default: begin
                stall_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            hold_q        <= '0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_rdata_q    <= '0;
            wb_alu_q      <= '0;
            wb_rd_q       <= 5'd0;
        end else begin
            dmem_req_q    <= dmem_req_d;
            dmem_we_q     <= dmem_we_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            hold_q        <= hold_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_rdata_q    <= wb_rdata_d;
            wb_alu_q      <= wb_alu_d;
            wb_rd_q       <= wb_rd_d;
        end
    end

    // Stall is forced low while reset is held so the pipeline is never frozen by a stale memop.
    assign stall             = stall_c & rst;
    assign dmem_req          = dmem_req_q;
    assign dmem_we           = dmem_we_q;
    assign dmem_addr         = dmem_addr_q;
    assign dmem_wdata        = dmem_wdata_q;
    assign mem_wb_regwrite   = wb_regwrite_q;
    assign mem_wb_memtoreg   = wb_memtoreg_q;
    assign mem_wb_rdata      = wb_rdata_q;
    assign mem_wb_alu_result = wb_alu_q;
    assign mem_wb_rd         = wb_rd_q;

endmodule
